// File: rtl/tx_radar_pkg.sv
// Shared types and constants for the HF radar transmit-chain controller.
//   tx_state_e : burst sequencer states
//   tx_cfg_t   : one software register set (shadow / staging payload)
package tx_radar_pkg;

    localparam int unsigned CFG_W        = 32;
    localparam int unsigned TX_MAX_DIG   = 32;
    localparam int unsigned TX_GUARD_CYC = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_e;

    typedef struct packed {
        logic [CFG_W-1:0] phase;
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] prt;
        logic [CFG_W-1:0] codigo;
        logic [CFG_W-1:0] num_dig;
        logic [CFG_W-1:0] t_b;
    } tx_cfg_t;

endpackage

// File: rtl/tx_cfg_check.sv
// Combinational validity check of one transmit register set.
//   i_cfg       : register set under test
//   o_valid_c   : 1 when num_dig in 1..MAX_DIG, t_b/prt/period non-zero, prt > period
module tx_cfg_check
    import tx_radar_pkg::*;
#(
    parameter int unsigned MAX_DIG = TX_MAX_DIG
) (
    input  tx_cfg_t i_cfg,
    output logic    o_valid_c
);

    logic w_dig_ok;
    logic w_nonzero_ok;
    logic w_unused;

    assign w_dig_ok     = (i_cfg.num_dig != '0) && (i_cfg.num_dig <= CFG_W'(MAX_DIG));
    assign w_nonzero_ok = (i_cfg.t_b != '0) && (i_cfg.prt != '0) && (i_cfg.period != '0);
    assign o_valid_c    = w_dig_ok && w_nonzero_ok && (i_cfg.prt > i_cfg.period);

    // Phase and code word never make a register set illegal.
    assign w_unused = &{1'b0, i_cfg.phase, i_cfg.codigo};

endmodule

// File: rtl/tx_burst_ctrl.sv
// Transmit burst sequencer: captures register sets into shadows, validates them,
// enables the sync generator for N pulses (or continuously) and applies live
// register updates only between sync pulses.
//   clk, rst            : ADC clock, synchronous active-low reset
//   start_i / stop_i    : burst start / stop-at-pulse-boundary requests
//   cfg_upd_i, cfg_*_i  : new software register set strobe and values
//   sinc_i              : sync output from the sync generator
//   *_o (32b)           : shadow registers to the datapath
//   tx_start_o, busy_o, done_o, cfg_err_o, pulse_cnt_o : status
module tx_burst_ctrl
    import tx_radar_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned GUARD_CYC = TX_GUARD_CYC,
    parameter int unsigned MAX_DIG   = TX_MAX_DIG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             cfg_upd_i,
    input  logic [CFG_W-1:0] cfg_phase_i,
    input  logic [CFG_W-1:0] cfg_period_i,
    input  logic [CFG_W-1:0] cfg_prt_i,
    input  logic [CFG_W-1:0] cfg_codigo_i,
    input  logic [CFG_W-1:0] cfg_num_dig_i,
    input  logic [CFG_W-1:0] cfg_t_b_i,
    input  logic [CNT_W-1:0] cfg_n_pulses_i,
    input  logic             sinc_i,
    output logic [CFG_W-1:0] phase_o,
    output logic [CFG_W-1:0] period_o,
    output logic [CFG_W-1:0] prt_o,
    output logic [CFG_W-1:0] codigo_o,
    output logic [CFG_W-1:0] num_dig_o,
    output logic [CFG_W-1:0] t_b_o,
    output logic             tx_start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o,
    output logic [CNT_W-1:0] pulse_cnt_o
);

    localparam int unsigned GUARD_W = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    tx_cfg_t            w_cfg_in;
    tx_cfg_t            r_shadow;
    tx_cfg_t            r_staging;
    logic               r_pending;
    logic               r_sinc_d;
    logic [CNT_W-1:0]   r_n_pulses;
    logic [CNT_W-1:0]   r_pulse_cnt;
    logic [GUARD_W-1:0] r_guard;
    logic               r_tx_start;
    logic               r_busy;
    logic               r_done;
    logic               r_cfg_err;
    logic               w_in_ok;
    logic               w_stage_ok;
    logic               w_sinc_rise;
    logic               w_sinc_fall;
    logic               w_cnt_hit;
    logic               w_guard_done;

    assign w_cfg_in = '{phase:   cfg_phase_i,
                        period:  cfg_period_i,
                        prt:     cfg_prt_i,
                        codigo:  cfg_codigo_i,
                        num_dig: cfg_num_dig_i,
                        t_b:     cfg_t_b_i};

    // Same rule checks the live inputs and the staged mid-burst update.
    tx_cfg_check #(.MAX_DIG(MAX_DIG)) u_chk_in (
        .i_cfg     (w_cfg_in),
        .o_valid_c (w_in_ok)
    );

    tx_cfg_check #(.MAX_DIG(MAX_DIG)) u_chk_stage (
        .i_cfg     (r_staging),
        .o_valid_c (w_stage_ok)
    );

    assign w_sinc_rise  = sinc_i & ~r_sinc_d;
    // First low cycle after a pulse: the only safe point to swap shadows.
    assign w_sinc_fall  = ~sinc_i & r_sinc_d;
    assign w_cnt_hit    = (r_n_pulses != '0) && (r_pulse_cnt >= r_n_pulses);
    assign w_guard_done = ~sinc_i && (r_guard == GUARD_W'(GUARD_CYC));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = w_in_ok ? ST_RUN : ST_IDLE;
            ST_RUN:   if (stop_i || w_cnt_hit) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_guard_done) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered status, shadows, staging and counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sinc_d    <= 1'b0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_pending   <= 1'b0;
            r_shadow    <= '0;
            r_staging   <= '0;
            r_n_pulses  <= '0;
            r_pulse_cnt <= '0;
            r_guard     <= '0;
        end else begin
            r_sinc_d   <= sinc_i;
            r_tx_start <= (w_state_nxt == ST_RUN);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_DONE);

            case (r_state)
                ST_IDLE: begin
                    r_pending <= 1'b0;
                    if (start_i) begin
                        r_cfg_err <= 1'b0;
                    end else if (cfg_upd_i) begin
                        if (w_in_ok) r_shadow  <= w_cfg_in;
                        else         r_cfg_err <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_n_pulses  <= cfg_n_pulses_i;
                    r_pulse_cnt <= '0;
                    if (w_in_ok) r_shadow  <= w_cfg_in;
                    else         r_cfg_err <= 1'b1;
                end
                ST_RUN: begin
                    if (w_sinc_rise && (r_pulse_cnt != {CNT_W{1'b1}}))
                        r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
                    if (w_sinc_fall && r_pending) begin
                        r_pending <= 1'b0;
                        if (w_stage_ok) r_shadow  <= r_staging;
                        else            r_cfg_err <= 1'b1;
                    end
                    // A strobe on the boundary cycle is staged for the next boundary.
                    if (cfg_upd_i) begin
                        r_pending <= 1'b1;
                        r_staging <= w_cfg_in;
                    end
                end
                default: begin
                    r_pending <= 1'b0;
                end
            endcase

            // Guard timer restarts whenever sync is high during drain.
            if (r_state == ST_DRAIN) begin
                if (sinc_i)             r_guard <= '0;
                else if (!w_guard_done) r_guard <= r_guard + GUARD_W'(1);
            end else begin
                r_guard <= '0;
            end
        end
    end

    assign phase_o     = r_shadow.phase;
    assign period_o    = r_shadow.period;
    assign prt_o       = r_shadow.prt;
    assign codigo_o    = r_shadow.codigo;
    assign num_dig_o   = r_shadow.num_dig;
    assign t_b_o       = r_shadow.t_b;
    assign tx_start_o  = r_tx_start;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign cfg_err_o   = r_cfg_err;
    assign pulse_cnt_o = r_pulse_cnt;

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// Self-checking bench for tx_burst_ctrl: validity table, directed corner
// sequences and randomized bursts against a transaction-level model.
module tb_tx_burst_ctrl;
    import tx_radar_pkg::*;

    localparam int unsigned GUARD = 64;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        stop_i;
    logic        cfg_upd_i;
    logic [31:0] cfg_phase_i, cfg_period_i, cfg_prt_i, cfg_codigo_i, cfg_num_dig_i, cfg_t_b_i;
    logic [15:0] cfg_n_pulses_i;
    logic        sinc_i;
    logic [31:0] phase_o, period_o, prt_o, codigo_o, num_dig_o, t_b_o;
    logic        tx_start_o, busy_o, done_o, cfg_err_o;
    logic [15:0] pulse_cnt_o;

    tx_burst_ctrl #(.CNT_W(16), .GUARD_CYC(GUARD), .MAX_DIG(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .cfg_upd_i      (cfg_upd_i),
        .cfg_phase_i    (cfg_phase_i),
        .cfg_period_i   (cfg_period_i),
        .cfg_prt_i      (cfg_prt_i),
        .cfg_codigo_i   (cfg_codigo_i),
        .cfg_num_dig_i  (cfg_num_dig_i),
        .cfg_t_b_i      (cfg_t_b_i),
        .cfg_n_pulses_i (cfg_n_pulses_i),
        .sinc_i         (sinc_i),
        .phase_o        (phase_o),
        .period_o       (period_o),
        .prt_o          (prt_o),
        .codigo_o       (codigo_o),
        .num_dig_o      (num_dig_o),
        .t_b_o          (t_b_o),
        .tx_start_o     (tx_start_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cfg_err_o      (cfg_err_o),
        .pulse_cnt_o    (pulse_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      errors = 0;
    int      checks = 0;
    tx_cfg_t m_shadow;
    bit      m_err;
    tx_cfg_t w_sh;

    assign w_sh = {phase_o, period_o, prt_o, codigo_o, num_dig_o, t_b_o};

    typedef struct {
        string   name;
        tx_cfg_t cfg;
        bit      exp_ok;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input tx_cfg_t c);
        cfg_phase_i   = c.phase;
        cfg_period_i  = c.period;
        cfg_prt_i     = c.prt;
        cfg_codigo_i  = c.codigo;
        cfg_num_dig_i = c.num_dig;
        cfg_t_b_i     = c.t_b;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_shadow = '0;
        m_err    = 1'b0;
    endtask

    // Reference legality rule, written straight from the register definition.
    function automatic bit ref_valid(input tx_cfg_t c);
        return (c.num_dig >= 1) && (c.num_dig <= 32) && (c.t_b != 0) &&
               (c.prt != 0) && (c.period != 0) && (c.prt > c.period);
    endfunction

    task automatic idle_upd(input tx_cfg_t c, input string tag);
        drive_cfg(c);
        cfg_upd_i = 1'b1;
        tick();
        cfg_upd_i = 1'b0;
        if (ref_valid(c)) m_shadow = c;
        else              m_err    = 1'b1;
        chk({tag, "_err"}, cfg_err_o, m_err);
        chk({tag, "_shadow"}, w_sh, m_shadow);
    endtask

    // Start a burst, act as the sync generator for k pulses (stop on the k-th
    // when n is 0) and check timing of tx_start, counter and done.
    task automatic burst(input tx_cfg_t c, input logic [15:0] n, input int k, input string tag);
        bit ok;
        int g, w, t;
        ok = ref_valid(c);
        drive_cfg(c);
        cfg_n_pulses_i = n;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk({tag, "_busy_load"}, busy_o, 1'b1);
        chk({tag, "_txs_load"}, tx_start_o, 1'b0);
        tick();
        if (!ok) begin
            m_err = 1'b1;
            chk({tag, "_txs_rej"}, tx_start_o, 1'b0);
            chk({tag, "_err_rej"}, cfg_err_o, 1'b1);
            chk({tag, "_busy_rej"}, busy_o, 1'b0);
            chk({tag, "_shadow_rej"}, w_sh, m_shadow);
            return;
        end
        m_shadow = c;
        m_err    = 1'b0;
        chk({tag, "_txs_rise"}, tx_start_o, 1'b1);
        chk({tag, "_err_clr"}, cfg_err_o, 1'b0);
        chk({tag, "_shadow_load"}, w_sh, m_shadow);
        chk({tag, "_cnt0"}, pulse_cnt_o, 16'd0);
        for (int p = 1; p <= k; p++) begin
            g = int'($urandom_range(5, 2));
            w = int'($urandom_range(6, 3));
            repeat (g) tick();
            sinc_i = 1'b1;
            tick();
            if (p == k && n == 0) stop_i = 1'b1;
            tick();
            stop_i = 1'b0;
            chk({tag, "_cnt"}, pulse_cnt_o, 16'(p));
            chk({tag, "_txs"}, tx_start_o, (p == k) ? 1'b0 : 1'b1);
            repeat (w - 2) tick();
            sinc_i = 1'b0;
        end
        t = 0;
        while (done_o !== 1'b1 && t < 3 * GUARD) begin
            tick();
            t++;
        end
        chk({tag, "_done_lat"}, t, GUARD + 1);
        chk({tag, "_cnt_done"}, pulse_cnt_o, 16'(k));
        chk({tag, "_busy_done"}, busy_o, 1'b1);
        tick();
        chk({tag, "_done_1cyc"}, done_o, 1'b0);
        chk({tag, "_busy_idle"}, busy_o, 1'b0);
        chk({tag, "_cnt_hold"}, pulse_cnt_o, 16'(k));
        chk({tag, "_err_end"}, cfg_err_o, m_err);
        chk({tag, "_shadow_end"}, w_sh, m_shadow);
    endtask

    function automatic tx_cfg_t rand_cfg();
        tx_cfg_t c;
        c.phase   = $urandom;
        c.codigo  = $urandom;
        c.period  = $urandom_range(1000, 1);
        c.prt     = c.period + $urandom_range(1000, 1);
        c.num_dig = $urandom_range(32, 1);
        c.t_b     = $urandom_range(255, 1);
        if ($urandom_range(9, 0) < 3) begin
            case ($urandom_range(5, 0))
                0:       c.num_dig = 0;
                1:       c.num_dig = 33 + $urandom_range(100, 0);
                2:       c.t_b     = 0;
                3:       c.prt     = 0;
                4:       c.period  = 0;
                default: c.prt     = $urandom_range(c.period, 0);
            endcase
        end
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_cfg_t base, c;
        int      ndone;
        logic [15:0] n;
        int      k;

        base.phase   = 32'h0001_2345;
        base.period  = 32'd25000;
        base.prt     = 32'd2500000;
        base.codigo  = 32'h0000_1F35;
        base.num_dig = 32'd13;
        base.t_b     = 32'd100;

        c = base;                          tbl[0] = '{"v_base",    c, 1'b1};
        c = base; c.num_dig = 0;           tbl[1] = '{"v_dig0",    c, 1'b0};
        c = base; c.num_dig = 32;          tbl[2] = '{"v_dig32",   c, 1'b1};
        c = base; c.num_dig = 33;          tbl[3] = '{"v_dig33",   c, 1'b0};
        c = base; c.t_b = 0;               tbl[4] = '{"v_tb0",     c, 1'b0};
        c = base; c.prt = 0;               tbl[5] = '{"v_prt0",    c, 1'b0};
        c = base; c.period = 0;            tbl[6] = '{"v_per0",    c, 1'b0};
        c = base; c.prt = 25000;           tbl[7] = '{"v_prt_eq",  c, 1'b0};
        c = base; c.prt = 25001;           tbl[8] = '{"v_prt_p1",  c, 1'b1};
        c = base; c.prt = 100;             tbl[9] = '{"v_prt_lt",  c, 1'b0};

        rst = 1'b0; start_i = 1'b0; stop_i = 1'b0; cfg_upd_i = 1'b0; sinc_i = 1'b0;
        cfg_n_pulses_i = '0;
        drive_cfg(base);
        tick();
        tick();
        rst = 1'b1;
        m_shadow = '0;
        m_err    = 1'b0;
        chk("reset_outputs", {tx_start_o, busy_o, done_o, cfg_err_o, pulse_cnt_o}, '0);
        chk("reset_shadow", w_sh, '0);

        // Validity table applied through idle-time register updates.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            drive_cfg(tbl[i].cfg);
            cfg_upd_i = 1'b1;
            tick();
            cfg_upd_i = 1'b0;
            chk({tbl[i].name, "_err"}, cfg_err_o, !tbl[i].exp_ok);
            chk({tbl[i].name, "_shadow"}, w_sh, tbl[i].exp_ok ? tbl[i].cfg : tx_cfg_t'('0));
        end

        // Basic 3-pulse burst.
        do_reset();
        burst(base, 16'd3, 3, "tp1");

        // Rejected starts leave shadows, then a good start clears the error.
        c = base; c.num_dig = 0;
        burst(c, 16'd3, 3, "tp2a");
        c = base; c.t_b = 0;
        burst(c, 16'd3, 3, "tp2b");
        burst(base, 16'd2, 2, "tp2c");

        // Continuous mode stopped during the 10th pulse.
        burst(base, 16'd0, 10, "tp3");

        // Live updates: deferred apply with overwrite, then a rejected update.
        drive_cfg(base);
        cfg_n_pulses_i = 16'd0;
        start_i = 1'b1; tick(); start_i = 1'b0; tick();
        m_shadow = base;
        repeat (2) tick();
        sinc_i = 1'b1; tick(); tick();
        cfg_phase_i = 32'h1111_1111; cfg_upd_i = 1'b1; tick();
        cfg_phase_i = 32'h010A_AAAA; tick(); cfg_upd_i = 1'b0;
        tick();
        chk("tp4_phase_hold_hi", phase_o, m_shadow.phase);
        sinc_i = 1'b0;
        chk("tp4_phase_hold_fall", phase_o, m_shadow.phase);
        tick();
        m_shadow.phase = 32'h010A_AAAA;
        chk("tp4_phase_applied", phase_o, 32'h010A_AAAA);
        chk("tp4_shadow", w_sh, m_shadow);
        repeat (3) tick();
        sinc_i = 1'b1; tick(); tick();
        cfg_prt_i = cfg_period_i; cfg_upd_i = 1'b1; tick(); cfg_upd_i = 1'b0;
        tick();
        sinc_i = 1'b0;
        tick();
        chk("tp5_err", cfg_err_o, 1'b1);
        chk("tp5_shadow_kept", w_sh, m_shadow);
        chk("tp5_still_running", tx_start_o, 1'b1);
        chk("tp5_cnt", pulse_cnt_o, 16'd2);
        repeat (3) tick();
        sinc_i = 1'b1; tick();
        stop_i = 1'b1; start_i = 1'b1; tick(); stop_i = 1'b0; start_i = 1'b0;
        chk("tp5_stop_txs", tx_start_o, 1'b0);
        repeat (2) tick();
        sinc_i = 1'b0;
        ndone = 0;
        for (int i = 0; i < 3 * GUARD; i++) begin
            tick();
            if (done_o === 1'b1) ndone++;
        end
        chk("tp5_done_once", ndone, 1);
        chk("tp5_err_sticky", cfg_err_o, 1'b1);
        chk("tp5_cnt_final", pulse_cnt_o, 16'd3);

        // Reset in the middle of a burst.
        drive_cfg(base);
        cfg_n_pulses_i = 16'd5;
        start_i = 1'b1; tick(); start_i = 1'b0; tick();
        repeat (2) tick();
        sinc_i = 1'b1; tick(); tick();
        rst = 1'b0; tick(); rst = 1'b1;
        m_shadow = '0; m_err = 1'b0;
        chk("tp6_outputs", {tx_start_o, busy_o, done_o, cfg_err_o, pulse_cnt_o}, '0);
        chk("tp6_shadow", w_sh, '0);
        sinc_i = 1'b0;
        ndone = 0;
        for (int i = 0; i < 2 * GUARD; i++) begin
            tick();
            if (done_o === 1'b1 || busy_o === 1'b1) ndone++;
        end
        chk("tp6_no_done", ndone, 0);

        // Randomized bursts and idle updates against the model.
        for (int it = 0; it < 10; it++) begin
            idle_upd(rand_cfg(), "rnd_upd");
            c = rand_cfg();
            n = 16'($urandom_range(4, 0));
            k = (n == 0) ? int'($urandom_range(4, 1)) : int'(n);
            burst(c, n, k, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
